board_eval: RTL and testbench
=============================

# board_eval

Downstream consumer of the per-piece move generators: it reads a run of contiguous 64-byte candidate boards that a generator has written to SDRAM and computes a signed material score for each. Each score is written as a 32-bit word to a result array. The block is an Avalon-MM accelerator with a slave register port for the HPS and a master port to SDRAM.

## Interface
Parameters:
- `MAX_BOARDS`, default 255. Maximum accepted board count; larger counts are clamped to this value.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `slave_waitrequest`  out  1  stall for the register port.
- `slave_address`  in  4  register select.
- `slave_read`  in  1  register read strobe.
- `slave_readdata`  out  32  register read data.
- `slave_write`  in  1  register write strobe.
- `slave_writedata`  in  32  register write data.
- `master_waitrequest`  in  1  SDRAM stall.
- `master_address`  out  32  byte address.
- `master_read`  out  1  read request.
- `master_readdata`  in  32  read data; piece code in bits [7:0].
- `master_readdatavalid`  in  1  read data valid.
- `master_write`  out  1  write request.
- `master_writedata`  out  32  score word.

## Operation
Registers:
- 0, write: start; data ignored. Ignored while busy.
- 0, read: returns `{16'd0, err_cnt[7:0], 7'd0, done}`.
- 1: boards base address.
- 2: result base address.
- 3: board count; bits [7:0] are used.
- Registers 1–3 are readable and are writable only while idle.

Piece values, from the signed 8-bit code:
- 1..8 (pawn): 100.
- 9..18 (rook): 500.
- 19..28 (knight): 320.
- 29..38 (bishop): 330.
- 39..47 (queen): 900.
- 48 (king): 0.
- 0: empty, contributes 0.
- Negative codes take the same magnitude classes and are subtracted.
- |code| > 48 contributes 0 and increments `err_cnt`, which saturates at 255.

Scoring:
- Score = Σ white − Σ black, computed as a 32-bit two's-complement value with sign-extended accumulation.

FSM states and transitions:
- IDLE → on start, clear `done` and `err_cnt`, set board k=0 and square s=0.
  - If count = 0, go directly to DONE.
- RD_REQ: assert `master_read` with `master_address` = base1 + 64k + s. Hold it until `master_waitrequest` = 0, then → RD_WAIT.
- RD_WAIT: wait for `master_readdatavalid`, then accumulate the piece value.
  - If s = 63 → WR; otherwise s++ and → RD_REQ.
- WR: assert `master_write` with `master_address` = base2 + 4k and `master_writedata` = score. Hold until `master_waitrequest` = 0.
  - Then clear the accumulator. If k = count−1 → DONE; otherwise k++, s=0, → RD_REQ.
- DONE: set `done`, → IDLE.

Master port rules:
- At most one outstanding read.
- `master_read` and `master_write` are never asserted together.
- Address and data are stable while the request is stalled.

## Timing
- Reset: `done` = 0, `err_cnt` = 0, all registers = 0, state IDLE.
- Reset values of outputs: `master_read`, `master_write`, `slave_waitrequest` = 0; `master_address`, `master_writedata`, `slave_readdata` = 0.
- Reset mid-run: requests drop immediately (asynchronously), no further SDRAM writes occur, and results already written remain in memory.
- Register writes complete in the cycle presented; `slave_waitrequest` = 0.
- Read of register 0 while busy: `slave_waitrequest` = 1 until the cycle `done` is set. Read data is valid in the cycle `slave_waitrequest` falls.
- Reads of other registers, and of register 0 while idle, do not stall.
- `master_readdatavalid` is honoured at the earliest one cycle after the read is accepted.
- Minimum latency with zero stalls: 2 cycles per square, so 129 cycles per board (including the write), plus 1 cycle for DONE.
- Scores are written in board order k = 0..count−1.
- Start while busy is ignored and does not restart the run.

## Test plan
- Standard opening position, count=1 → word 0x00000000 at base2; status reads 0x00000001.
- Board holding only WKING, WQUEEN0, BKING, BROOK0 → 0x00000190 (400).
- count=3 with scores +400, −100, +320 → 0x00000190, 0xFFFFFF9C, 0x00000140 at base2+0/+4/+8, in that order; exactly 3 writes.
- Case 3 repeated with `master_waitrequest` high 3 cycles on every request and `readdatavalid` delayed 2 cycles → identical memory contents; address is stable during stalls.
- Code 0x40 on one square of an otherwise empty board → score 0; status reads 0x00000101.
- count=0 → done with no master activity. Separately, assert `rst` mid-board 2 of 3 → outputs drop the same cycle, only the board-0 result is written, and the status register reads 0.

Source files
------------

// File: rtl/board_eval.sv
// board_eval: walks a run of 64-byte candidate boards in SDRAM, scores each
// board by material (white positive, black negative) and writes one signed
// 32-bit score word per board to a result array.
module board_eval #(
  parameter int unsigned MAX_BOARDS = 255
) (
  input  logic        clk,
  input  logic        rst,
  // Register port
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  // SDRAM master port
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdReq  = 3'd1;
  localparam logic [2:0] StRdWait = 3'd2;
  localparam logic [2:0] StWr     = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  // Count register is 8 bits wide, so the clamp can never exceed 255.
  localparam int unsigned MaxEff = (MAX_BOARDS > 255) ? 255 : MAX_BOARDS;
  localparam logic [7:0]  MaxCnt = MaxEff[7:0];

  logic [2:0]  state_q, state_d;
  logic [31:0] base1_q, base1_d;
  logic [31:0] base2_q, base2_d;
  logic [7:0]  count_q, count_d;
  logic        done_q, done_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  k_q, k_d;
  logic [5:0]  s_q, s_d;
  logic [31:0] acc_q, acc_d;

  logic        idle;
  logic [7:0]  cnt_eff;
  logic        start;

  logic        code_neg;
  logic [7:0]  code_mag;
  logic [9:0]  piece_val;
  logic        piece_bad;
  logic [31:0] piece_delta;

  // Only the piece code byte of each read word carries information.
  logic        unused_rdata;
  assign unused_rdata = ^master_readdata[31:8];

  assign idle    = (state_q == StIdle);
  assign cnt_eff = (count_q > MaxCnt) ? MaxCnt : count_q;
  assign start   = slave_write && (slave_address == 4'd0) && idle;

  // Decode the signed piece code into a signed contribution and an error flag.
  always_comb begin
    code_neg  = master_readdata[7];
    // |-128| wraps to 8'h80 = 128, which correctly lands in the error range.
    code_mag  = code_neg ? (8'd0 - master_readdata[7:0]) : master_readdata[7:0];
    piece_val = 10'd0;
    piece_bad = 1'b0;
    if (code_mag == 8'd0) begin
      piece_val = 10'd0;
    end else if (code_mag <= 8'd8) begin
      piece_val = 10'd100;
    end else if (code_mag <= 8'd18) begin
      piece_val = 10'd500;
    end else if (code_mag <= 8'd28) begin
      piece_val = 10'd320;
    end else if (code_mag <= 8'd38) begin
      piece_val = 10'd330;
    end else if (code_mag <= 8'd47) begin
      piece_val = 10'd900;
    end else if (code_mag == 8'd48) begin
      piece_val = 10'd0;
    end else begin
      piece_bad = 1'b1;
    end
    piece_delta = code_neg ? (32'd0 - {22'd0, piece_val}) : {22'd0, piece_val};
  end

  // Next-state logic: register writes while idle, plus the scan sequencer.
  always_comb begin
    state_d = state_q;
    base1_d = base1_q;
    base2_d = base2_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q;
    k_d     = k_q;
    s_d     = s_q;
    acc_d   = acc_q;

    if (slave_write && idle) begin
      case (slave_address)
        4'd1:    base1_d = slave_writedata;
        4'd2:    base2_d = slave_writedata;
        4'd3:    count_d = slave_writedata[7:0];
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 8'd0;
          k_d     = 8'd0;
          s_d     = 6'd0;
          acc_d   = 32'd0;
          state_d = (cnt_eff == 8'd0) ? StDone : StRdReq;
        end
      end
      StRdReq: begin
        if (!master_waitrequest) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (master_readdatavalid) begin
          acc_d = acc_q + piece_delta;
          if (piece_bad && (err_q != 8'hff)) begin
            err_d = err_q + 8'd1;
          end
          if (s_q == 6'd63) begin
            state_d = StWr;
          end else begin
            s_d     = s_q + 6'd1;
            state_d = StRdReq;
          end
        end
      end
      StWr: begin
        if (!master_waitrequest) begin
          acc_d = 32'd0;
          if (k_q == (cnt_eff - 8'd1)) begin
            state_d = StDone;
          end else begin
            k_d     = k_q + 8'd1;
            s_d     = 6'd0;
            state_d = StRdReq;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and register file; reset clears everything and drops requests at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      base1_q <= 32'd0;
      base2_q <= 32'd0;
      count_q <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 8'd0;
      k_q     <= 8'd0;
      s_q     <= 6'd0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      base1_q <= base1_d;
      base2_q <= base2_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      k_q     <= k_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
    end
  end

  // Master outputs are pure functions of registered state, so they stay stable under stall.
  always_comb begin
    master_read      = (state_q == StRdReq);
    master_write     = (state_q == StWr);
    master_address   = 32'd0;
    master_writedata = 32'd0;
    if (state_q == StRdReq) begin
      // k*64 + s, since s never exceeds 63.
      master_address = base1_q + {18'd0, k_q, s_q};
    end else if (state_q == StWr) begin
      master_address   = base2_q + {22'd0, k_q, 2'b00};
      master_writedata = acc_q;
    end
  end

  // Register reads; a status read stalls until the run has finished.
  always_comb begin
    slave_waitrequest = slave_read && (slave_address == 4'd0) && !idle;
    slave_readdata    = 32'd0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = {16'd0, err_q, 7'd0, done_q};
        4'd1:    slave_readdata = base1_q;
        4'd2:    slave_readdata = base2_q;
        4'd3:    slave_readdata = {24'd0, count_q};
        default: slave_readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval with a small SDRAM responder model.
module tb_board_eval;

  localparam logic [31:0] B1 = 32'h0000_1000;
  localparam logic [31:0] B2 = 32'h0000_8000;

  logic        clk;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  board_eval #(.MAX_BOARDS(255)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_fail;

  // SDRAM model: 256 bytes of board storage at B1, captured result writes.
  logic [7:0]  bmem [0:255];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          stall_n;
  int          rd_lat;
  int          stall_ctr;
  logic        pend;
  int          pend_ctr;
  logic [7:0]  pend_addr;
  int          act_cnt;
  int          viol;
  logic        held;
  logic        h_rd;
  logic [31:0] h_addr;
  logic [31:0] h_data;

  assign master_waitrequest = (master_read || master_write) && (stall_ctr < stall_n);

  // Stall counter: each request sees stall_n waitrequest cycles.
  always @(posedge clk) begin
    if (rst || !(master_read || master_write)) stall_ctr <= 0;
    else if (master_waitrequest) stall_ctr <= stall_ctr + 1;
    else stall_ctr <= 0;
  end

  // Read responder: data arrives rd_lat cycles after the earliest legal cycle.
  always @(posedge clk) begin
    if (rst) begin
      master_readdatavalid <= 1'b0;
      master_readdata      <= 32'd0;
      pend                 <= 1'b0;
      pend_ctr             <= 0;
    end else begin
      master_readdatavalid <= 1'b0;
      if (master_read && !master_waitrequest) begin
        if (rd_lat == 0) begin
          master_readdatavalid <= 1'b1;
          master_readdata      <= {24'hA5A5A5, bmem[master_address[7:0]]};
        end else begin
          pend      <= 1'b1;
          pend_ctr  <= rd_lat;
          pend_addr <= master_address[7:0];
        end
      end else if (pend) begin
        if (pend_ctr == 1) begin
          master_readdatavalid <= 1'b1;
          master_readdata      <= {24'h5A5A5A, bmem[pend_addr]};
          pend                 <= 1'b0;
        end else begin
          pend_ctr <= pend_ctr - 1;
        end
      end
    end
  end

  // Protocol monitor and result capture.
  always @(posedge clk) begin
    if (rst) begin
      held <= 1'b0;
    end else begin
      if (master_read || master_write) act_cnt <= act_cnt + 1;
      if (master_write && !master_waitrequest) begin
        wr_addr_q.push_back(master_address);
        wr_data_q.push_back(master_writedata);
      end
      viol <= viol
            + ((master_read && master_write) ? 1 : 0)
            + ((held && (!(master_read || master_write) || master_read !== h_rd ||
                master_address !== h_addr || master_writedata !== h_data)) ? 1 : 0)
            + ((master_read && !master_waitrequest && (pend || master_readdatavalid)) ? 1 : 0)
            + ((master_read && master_address[31:8] != B1[31:8]) ? 1 : 0);
      held   <= (master_read || master_write) && master_waitrequest;
      h_rd   <= master_read;
      h_addr <= master_address;
      h_data <= master_writedata;
    end
  end

  typedef struct packed {
    logic [3:0][5:0] sq;
    logic [3:0][7:0] code;
    logic [31:0]     score;
    logic [31:0]     status;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(negedge clk);
    slave_write     = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_read    = 1'b1;
    #1 d = slave_readdata;
    slave_read    = 1'b0;
  endtask

  // Stalling status read; cyc counts sampled cycles with waitrequest high.
  task automatic wait_done(output int cyc, output logic [31:0] st);
    slave_address = 4'd0;
    slave_read    = 1'b1;
    cyc = 0;
    forever begin
      #1;
      if (!slave_waitrequest) break;
      cyc++;
      if (cyc > 3000) break;
      @(negedge clk);
    end
    st         = slave_readdata;
    slave_read = 1'b0;
    if (cyc > 3000) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout: got busy after %0d cycles expected done", cyc);
    end
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) bmem[i] = v;
  endtask

  task automatic place(input int k, input vec_t v);
    for (int i = 0; i < 4; i++) bmem[k * 64 + int'(v.sq[i])] = v.code[i];
  endtask

  task automatic clear_wr();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_three(input string tag);
    chk({tag, "_nwr"}, wr_addr_q.size(), 3);
    if (wr_addr_q.size() == 3) begin
      chk({tag, "_a0"}, wr_addr_q[0], B2);
      chk({tag, "_d0"}, wr_data_q[0], 32'h0000_0190);
      chk({tag, "_a1"}, wr_addr_q[1], B2 + 32'd4);
      chk({tag, "_d1"}, wr_data_q[1], 32'hFFFF_FF9C);
      chk({tag, "_a2"}, wr_addr_q[2], B2 + 32'd8);
      chk({tag, "_d2"}, wr_data_q[2], 32'h0000_0140);
    end
  endtask

  task automatic setup_three();
    fill_mem(8'd0);
    place(0, vecs[1]);
    bmem[64 + 50]  = 8'hFF;
    bmem[128 + 20] = 8'd19;
  endtask

  int          cyc;
  logic [31:0] st;
  logic [31:0] d;
  int          act0;

  initial begin
    n_vec = 0; n_fail = 0; stall_n = 0; rd_lat = 0; act_cnt = 0; viol = 0;
    slave_address = 4'd0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = 32'd0;
    rst = 1'b1;

    vecs[0] = '{sq: {6'd0, 6'd1, 6'd2, 6'd3}, code: {8'h00, 8'h00, 8'h00, 8'h00},
                score: 32'h0000_0000, status: 32'h0000_0001};
    vecs[1] = '{sq: {6'd4, 6'd3, 6'd60, 6'd56}, code: {8'd48, 8'd39, 8'hD0, 8'hF7},
                score: 32'h0000_0190, status: 32'h0000_0001};
    vecs[2] = '{sq: {6'd10, 6'd11, 6'd12, 6'd13}, code: {8'h40, 8'h00, 8'h00, 8'h00},
                score: 32'h0000_0000, status: 32'h0000_0101};
    vecs[3] = '{sq: {6'd50, 6'd51, 6'd52, 6'd53}, code: {8'hFF, 8'h00, 8'h00, 8'h00},
                score: 32'hFFFF_FF9C, status: 32'h0000_0001};
    vecs[4] = '{sq: {6'd0, 6'd63, 6'd1, 6'd2}, code: {8'd47, 8'hDA, 8'h00, 8'h00},
                score: 32'h0000_023A, status: 32'h0000_0001};
    vecs[5] = '{sq: {6'd1, 6'd2, 6'd3, 6'd4}, code: {8'd8, 8'd18, 8'd28, 8'h00},
                score: 32'h0000_0398, status: 32'h0000_0001};
    vecs[6] = '{sq: {6'd5, 6'd6, 6'd7, 6'd8}, code: {8'h80, 8'h31, 8'd1, 8'h00},
                score: 32'h0000_0064, status: 32'h0000_0201};
    vecs[7] = '{sq: {6'd20, 6'd21, 6'd22, 6'd23}, code: {8'd19, 8'd29, 8'hD1, 8'd9},
                score: 32'h0000_00FA, status: 32'h0000_0001};

    repeat (3) @(negedge clk);
    chk("rst_mreq", {30'd0, master_read, master_write}, 32'd0);
    chk("rst_maddr", master_address, 32'd0);
    chk("rst_mdata", master_writedata, 32'd0);
    chk("rst_swait", {31'd0, slave_waitrequest}, 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      reg_rd(4'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 32'd0);
    end

    reg_wr(4'd1, B1);
    reg_wr(4'd2, B2);
    reg_wr(4'd3, 32'd1);
    reg_rd(4'd1, d); chk("rb_base1", d, B1);
    reg_rd(4'd2, d); chk("rb_base2", d, B2);
    reg_rd(4'd3, d); chk("rb_count", d, 32'd1);

    // Single-board vectors.
    for (int v = 0; v < 8; v++) begin
      fill_mem(8'd0);
      place(0, vecs[v]);
      clear_wr();
      reg_wr(4'd0, 32'd0);
      wait_done(cyc, st);
      chk($sformatf("v%0d_cycles", v), cyc, 32'd130);
      chk($sformatf("v%0d_status", v), st, vecs[v].status);
      chk($sformatf("v%0d_nwr", v), wr_addr_q.size(), 32'd1);
      if (wr_addr_q.size() == 1) begin
        chk($sformatf("v%0d_addr", v), wr_addr_q[0], B2);
        chk($sformatf("v%0d_score", v), wr_data_q[0], vecs[v].score);
      end
    end

    // Standard opening position.
    fill_mem(8'd0);
    bmem[0] = 8'd9;  bmem[1] = 8'd19; bmem[2] = 8'd29; bmem[3] = 8'd39;
    bmem[4] = 8'd48; bmem[5] = 8'd30; bmem[6] = 8'd20; bmem[7] = 8'd10;
    for (int i = 0; i < 8; i++) begin
      bmem[8 + i]  = 8'(i + 1);
      bmem[48 + i] = 8'd0 - 8'(i + 1);
      bmem[56 + i] = 8'd0 - bmem[i];
    end
    clear_wr();
    reg_wr(4'd0, 32'd0);
    wait_done(cyc, st);
    chk("open_status", st, 32'h0000_0001);
    chk("open_nwr", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) chk("open_score", wr_data_q[0], 32'd0);

    // Three boards, no stalls.
    setup_three();
    clear_wr();
    reg_wr(4'd3, 32'd3);
    reg_wr(4'd0, 32'd0);
    wait_done(cyc, st);
    chk("three_cycles", cyc, 32'd388);
    chk("three_status", st, 32'h0000_0001);
    check_three("three");

    // Same run with stalls and slow read data; busy writes must be ignored.
    stall_n = 3;
    rd_lat  = 2;
    clear_wr();
    reg_wr(4'd0, 32'd0);
    repeat (50) @(negedge clk);
    reg_wr(4'd1, 32'hDEAD_0000);
    reg_wr(4'd0, 32'd0);
    wait_done(cyc, st);
    chk("stall_status", st, 32'h0000_0001);
    check_three("stall");
    reg_rd(4'd1, d);
    chk("busy_wr_ignored", d, B1);
    chk("protocol_viol", viol, 32'd0);
    stall_n = 0;
    rd_lat  = 0;

    // Error counter saturates at 255 over 256 bad codes.
    fill_mem(8'h40);
    clear_wr();
    reg_wr(4'd3, 32'd4);
    reg_wr(4'd0, 32'd0);
    wait_done(cyc, st);
    chk("sat_cycles", cyc, 32'd517);
    chk("sat_status", st, 32'h0000_FF01);
    chk("sat_nwr", wr_addr_q.size(), 32'd4);
    if (wr_addr_q.size() == 4) chk("sat_last", wr_data_q[3], 32'd0);

    // Zero count: straight to done, no master activity.
    clear_wr();
    reg_wr(4'd3, 32'd0);
    act0 = act_cnt;
    reg_wr(4'd0, 32'd0);
    wait_done(cyc, st);
    chk("zero_cycles", cyc, 32'd1);
    chk("zero_status", st, 32'h0000_0001);
    chk("zero_activity", act_cnt - act0, 32'd0);

    // Reset during the second board of three.
    setup_three();
    clear_wr();
    reg_wr(4'd3, 32'd3);
    reg_wr(4'd0, 32'd0);
    for (int i = 0; i < 2000 && wr_addr_q.size() < 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4 && !master_read; i++) @(negedge clk);
    chk("mid_board0_written", wr_addr_q.size(), 32'd1);
    chk("mid_read_active", {31'd0, master_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", {30'd0, master_read, master_write}, 32'd0);
    chk("mid_rst_addr", master_address, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    chk("mid_nwr", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() >= 1) chk("mid_d0", wr_data_q[0], 32'h0000_0190);
    reg_rd(4'd0, d); chk("mid_status", d, 32'd0);
    reg_rd(4'd1, d); chk("mid_base1", d, 32'd0);
    chk("protocol_viol_end", viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
